spi_transaction_arbiter: RTL and testbench

SPI_TRANSACTION_ARBITER -- requirements
Module: spi_transaction_arbiter

---
 rtl/spi_transaction_arbiter_if.sv | 39 +++
 rtl/spi_transaction_arbiter.sv | 147 ++++++++++++++
 tb/tb_spi_transaction_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spi_transaction_arbiter_if.sv
// Bundle shared by the arbiter: client request/response lanes plus the SPI master control side.
// The arbiter uses the slave modport; the driving environment uses master.
interface spi_transaction_arbiter_if #(
  parameter int NUM_REQUESTERS      = 4,
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int NUMBER_OF_SLAVES    = 2
);
  logic                                           enable;
  logic [NUM_REQUESTERS-1:0]                      req;
  logic [NUM_REQUESTERS*NUMBER_OF_SLAVES-1:0]     req_slave;
  logic [NUM_REQUESTERS-1:0]                      req_operation;
  logic [NUM_REQUESTERS*OUTGOING_DATA_WIDTH-1:0]  req_data;
  logic [NUM_REQUESTERS-1:0]                      grant;
  logic [NUM_REQUESTERS-1:0]                      done;
  logic [INCOMING_DATA_WIDTH-1:0]                 rdata;
  logic                                           timeout_err;
  logic                                           spi_enable;
  logic                                           spi_start_transaction;
  logic                                           spi_operation;
  logic [NUMBER_OF_SLAVES-1:0]                    spi_slave;
  logic [OUTGOING_DATA_WIDTH-1:0]                 spi_outgoing_data;
  logic                                           spi_end_of_transaction;
  logic [INCOMING_DATA_WIDTH-1:0]                 spi_incoming_data;

  modport slave (
    input  enable, req, req_slave, req_operation, req_data,
           spi_end_of_transaction, spi_incoming_data,
    output grant, done, rdata, timeout_err, spi_enable, spi_start_transaction,
           spi_operation, spi_slave, spi_outgoing_data
  );

  modport master (
    output enable, req, req_slave, req_operation, req_data,
           spi_end_of_transaction, spi_incoming_data,
    input  grant, done, rdata, timeout_err, spi_enable, spi_start_transaction,
           spi_operation, spi_slave, spi_outgoing_data
  );
endinterface

// File: rtl/spi_transaction_arbiter.sv
// Round-robin arbiter multiplexing several clients onto one SPI master, with a BUSY-state
// watchdog that forces completion (rdata=0, timeout_err) if the master never ends the transfer.
module spi_transaction_arbiter #(
  parameter int NUM_REQUESTERS      = 4,
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int NUMBER_OF_SLAVES    = 2,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  spi_transaction_arbiter_if.slave bus
);
  localparam int NR   = NUM_REQUESTERS;
  localparam int IW   = INCOMING_DATA_WIDTH;
  localparam int OW   = OUTGOING_DATA_WIDTH;
  localparam int NS   = NUMBER_OF_SLAVES;
  localparam int IDXW = (NR > 1) ? $clog2(NR) : 1;
  localparam int CW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [NR-1:0]   grant_q, grant_d;
  logic [NR-1:0]   done_q, done_d;
  logic [IW-1:0]   rdata_q, rdata_d;
  logic            terr_q, terr_d;
  logic            start_q, start_d;
  logic            spi_en_q, spi_en_d;
  logic            op_q, op_d;
  logic [NS-1:0]   slave_q, slave_d;
  logic [OW-1:0]   odata_q, odata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [IDXW-1:0] own_q, own_d;

  logic [2*NR-1:0] rot, rot_sh;
  logic [NR-1:0]   opv;
  logic [IDXW-1:0] pick;
  int              fj;

  // Rotate the request vector so bit 0 is the client right after last_owner; first set bit wins.
  always_comb begin
    rot = {bus.req, bus.req} >> (int'(last_q) + 1);
    fj  = 0;
    for (int j = NR - 1; j >= 0; j--) begin
      rot_sh = rot >> j;
      if (rot_sh[0]) fj = j;
    end
    pick = IDXW'((int'(last_q) + 1 + fj) % NR);
    opv  = bus.req_operation >> pick;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    terr_d   = 1'b0;
    start_d  = 1'b0;
    spi_en_d = 1'b1;
    op_d     = op_q;
    slave_d  = slave_q;
    odata_d  = odata_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    own_d    = own_q;
    case (state_q)
      IDLE: if (bus.enable && (|bus.req)) begin
        own_d   = pick;
        grant_d = NR'(1) << pick;
        slave_d = NS'(bus.req_slave >> (int'(pick) * NS));
        odata_d = OW'(bus.req_data >> (int'(pick) * OW));
        op_d    = opv[0];
        start_d = 1'b1;
        state_d = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // End-of-transaction wins over a coinciding timeout.
        if (bus.spi_end_of_transaction) begin
          rdata_d = bus.spi_incoming_data;
          done_d  = grant_q;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          done_d  = grant_q;
          terr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        grant_d = '0;
        last_d  = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      terr_q   <= 1'b0;
      start_q  <= 1'b0;
      spi_en_q <= 1'b0;
      op_q     <= 1'b0;
      slave_q  <= '0;
      odata_q  <= '0;
      cnt_q    <= '0;
      last_q   <= IDXW'(NR - 1);
      own_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      terr_q   <= terr_d;
      start_q  <= start_d;
      spi_en_q <= spi_en_d;
      op_q     <= op_d;
      slave_q  <= slave_d;
      odata_q  <= odata_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      own_q    <= own_d;
    end
  end

  assign bus.grant                 = grant_q;
  assign bus.done                  = done_q;
  assign bus.rdata                 = rdata_q;
  assign bus.timeout_err           = terr_q;
  assign bus.spi_enable            = spi_en_q;
  assign bus.spi_start_transaction = start_q;
  assign bus.spi_operation         = op_q;
  assign bus.spi_slave             = slave_q;
  assign bus.spi_outgoing_data     = odata_q;
endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// Transaction-level bench: each transfer is predicted from round-robin order, BUSY length and
// the watchdog limit, then checked cycle by cycle against the arbiter outputs.
module tb_spi_transaction_arbiter;
  localparam int NR = 4, IW = 8, OW = 16, NS = 2, TO = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spi_transaction_arbiter_if #(.NUM_REQUESTERS(NR), .INCOMING_DATA_WIDTH(IW),
    .OUTGOING_DATA_WIDTH(OW), .NUMBER_OF_SLAVES(NS)) bus ();

  spi_transaction_arbiter #(.NUM_REQUESTERS(NR), .INCOMING_DATA_WIDTH(IW),
    .OUTGOING_DATA_WIDTH(OW), .NUMBER_OF_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  int n_chk = 0, n_pass = 0;
  int last_owner;
  logic [IW-1:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int rr(input int last, input logic [NR-1:0] m);
    for (int k = 1; k <= NR; k++) begin
      int idx = (last + k) % NR;
      if (((m >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic rand_fields();
    bus.req_slave     = NR*NS'($urandom);
    bus.req_operation = NR'($urandom);
    bus.req_data      = {$urandom, $urandom};
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_terr"}, 32'(bus.timeout_err), 0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 0);
    chk({tag, "_start"}, 32'(bus.spi_start_transaction), 0);
    chk({tag, "_spien"}, 32'(bus.spi_enable), 0);
    chk({tag, "_op"}, 32'(bus.spi_operation), 0);
    chk({tag, "_slave"}, 32'(bus.spi_slave), 0);
    chk({tag, "_odata"}, 32'(bus.spi_outgoing_data), 0);
  endtask

  // Entered and left at a negedge in IDLE. lat = BUSY cycles before end_of_transaction;
  // lat < 0 or lat >= TO means the master never answers inside the watchdog window.
  task automatic do_txn(input logic [NR-1:0] m, input int lat, input bit mutate,
                        input int hold, input int din_v);
    int own, fin;
    bit to;
    logic [IW-1:0] din;
    logic [NS-1:0] e_slave;
    logic e_op;
    logic [OW-1:0] e_data;
    din = '0;
    bus.req = m;
    rand_fields();
    if (hold > 0) begin
      bus.enable = 1'b0;
      repeat (hold) begin
        bus.spi_end_of_transaction = 1'($urandom);
        @(negedge clk);
        chk("hold_grant", 32'(bus.grant), 0);
        chk("hold_start", 32'(bus.spi_start_transaction), 0);
      end
    end
    bus.enable = 1'b1;
    bus.spi_end_of_transaction = 1'($urandom);
    own     = rr(last_owner, m);
    e_slave = NS'(bus.req_slave >> (own * NS));
    e_op    = 1'(bus.req_operation >> own);
    e_data  = OW'(bus.req_data >> (own * OW));
    @(negedge clk);
    chk("grant", 32'(bus.grant), 32'(1 << own));
    chk("start", 32'(bus.spi_start_transaction), 1);
    chk("slave", 32'(bus.spi_slave), 32'(e_slave));
    chk("op", 32'(bus.spi_operation), 32'(e_op));
    chk("odata", 32'(bus.spi_outgoing_data), 32'(e_data));
    chk("spien", 32'(bus.spi_enable), 1);
    bus.spi_end_of_transaction = 1'($urandom);
    if (mutate) begin
      rand_fields();
      bus.req    = m & ~(NR'(1) << own);
      bus.enable = 1'($urandom);
    end
    to  = (lat < 0) || (lat > TO - 1);
    fin = to ? TO - 1 : lat;
    for (int c = 0; c <= fin; c++) begin
      @(negedge clk);
      chk("busy_done", 32'(bus.done), 0);
      chk("busy_start", 32'(bus.spi_start_transaction), 0);
      chk("busy_grant", 32'(bus.grant), 32'(1 << own));
      din = IW'($urandom);
      if (din_v >= 0) din = IW'(din_v);
      bus.spi_incoming_data = din;
      bus.spi_end_of_transaction = (c == lat);
    end
    @(negedge clk);
    bus.spi_end_of_transaction = 1'($urandom);
    exp_rdata = to ? '0 : din;
    chk("done", 32'(bus.done), 32'(1 << own));
    chk("terr", 32'(bus.timeout_err), 32'(to));
    chk("rdata", 32'(bus.rdata), 32'(exp_rdata));
    chk("done_grant", 32'(bus.grant), 32'(1 << own));
    chk("done_odata", 32'(bus.spi_outgoing_data), 32'(e_data));
    chk("done_slave", 32'(bus.spi_slave), 32'(e_slave));
    last_owner = own;
    @(negedge clk);
    chk("idle_grant", 32'(bus.grant), 0);
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_terr", 32'(bus.timeout_err), 0);
    chk("idle_rdata", 32'(bus.rdata), 32'(exp_rdata));
    bus.req = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.enable = 1'b0;
    bus.req = '0;
    bus.req_slave = '0;
    bus.req_operation = '0;
    bus.req_data = '0;
    bus.spi_end_of_transaction = 1'b0;
    bus.spi_incoming_data = '0;
    last_owner = NR - 1;
    exp_rdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_spien", 32'(bus.spi_enable), 1);
    chk("post_rst_grant", 32'(bus.grant), 0);

    do_txn(4'b0001, 3, 1'b0, 0, 8'hA5);
    repeat (5) do_txn(4'b1111, int'($urandom_range(0, 5)), 1'b0, 0, -1);
    do_txn(4'b0010, 2, 1'b0, 3, -1);
    do_txn(4'b0110, -1, 1'b0, 0, -1);
    do_txn(4'b1001, TO - 1, 1'b0, 0, -1);
    do_txn(4'b0101, 4, 1'b1, 0, -1);

    // Reset in the middle of BUSY: everything clears, no done, client 0 regains first priority.
    bus.enable = 1'b1;
    bus.req = 4'b0100;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    bus.req = '0;
    bus.spi_end_of_transaction = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset_n = 1'b1;
    bus.spi_end_of_transaction = 1'b0;
    last_owner = NR - 1;
    exp_rdata = '0;
    @(negedge clk);
    chk("midrst_nodone", 32'(bus.done), 0);
    do_txn(4'b1000, 1, 1'b0, 0, -1);

    for (int t = 0; t < 60; t++) begin
      logic [NR-1:0] m;
      m = NR'($urandom_range(1, (1 << NR) - 1));
      if ($urandom_range(0, 3) == 0) begin
        bus.enable = 1'($urandom);
        repeat ($urandom_range(1, 3)) begin
          bus.spi_end_of_transaction = 1'($urandom);
          @(negedge clk);
          chk("gap_grant", 32'(bus.grant), 0);
        end
      end
      do_txn(m, int'($urandom_range(0, 20)), 1'($urandom), int'($urandom_range(0, 2)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
